// File: rtl/lock_access_controller_pkg.sv
// lock_access_controller_pkg: shared state type, counter widths and default code for the two-button lock.
package lock_ctrl_pkg;
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT, PROGRAM} lock_state_e;
  localparam int CNT_W = 5;
  localparam int TIMER_W = 16;
  localparam logic [15:0] LOCK_DEFAULT_CODE = 16'b01011;
endpackage

// File: rtl/lock_access_controller_if.sv
// lock_access_controller_if: button inputs and lock status outputs between debounce logic and actuator.
interface lock_access_controller_if #(
  parameter int MAX_FAILS = 3
) ();
  logic b0;
  logic b1;
  logic prog_req;
  logic unlock;
  logic lockout;
  logic prog_mode;
  logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt;
  modport master (output b0, b1, prog_req, input unlock, lockout, prog_mode, fail_cnt);
  modport slave (input b0, b1, prog_req, output unlock, lockout, prog_mode, fail_cnt);
endinterface

// File: rtl/lock_access_controller_timer.sv
// lock_cycle_timer: loadable down counter that holds at zero and flags it.
module lock_cycle_timer
  import lock_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);
  logic [TIMER_W-1:0] value_q;
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else if (load_i) value_q <= load_val_i;
    else if (value_q != '0) value_q <= value_q - TIMER_W'(1);
  end
  assign zero_o = value_q == '0;
endmodule

// File: rtl/lock_access_controller.sv
// lock_access_controller: serial code entry, timed unlock, fail lockout and code reprogramming.
// Define LOCK_ENTRY_TIMEOUT_EN to discard partial entries after ENTRY_TIMEOUT idle cycles.
module lock_access_controller
  import lock_ctrl_pkg::*;
#(
  parameter int                 CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = CODE_LEN'(LOCK_DEFAULT_CODE),
  parameter int                 UNLOCK_CYCLES  = 4,
  parameter int                 MAX_FAILS      = 3,
  parameter int                 LOCKOUT_CYCLES = 8,
  parameter int                 ENTRY_TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  lock_access_controller_if.slave   bus
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  lock_state_e          state_q;
  logic [CODE_LEN-1:0]  code_q, entry_q, entry_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [FW-1:0]        fail_q;
  logic                 unlock_q, lockout_q, prog_q;
  logic                 dig, abort, last, match, win_load, win_zero, idle_to;
  logic [TIMER_W-1:0]   win_val;
  always_comb begin
    dig      = bus.b0 ^ bus.b1;
    abort    = bus.b0 & bus.b1;
    entry_d  = CODE_LEN'({entry_q, bus.b1});
    last     = cnt_q == CNT_W'(CODE_LEN - 1);
    match    = entry_d == code_q;
    win_load = state_q == ENTRY && dig && last;
    win_val  = match ? TIMER_W'(UNLOCK_CYCLES - 1) : TIMER_W'(LOCKOUT_CYCLES - 1);
  end
  // One timer serves both the unlock and the lockout window; they never overlap.
  lock_cycle_timer u_win (
    .clk        (clk),
    .rst        (reset),
    .load_i     (win_load),
    .load_val_i (win_val),
    .zero_o     (win_zero)
  );
`ifdef LOCK_ENTRY_TIMEOUT_EN
  logic idle_zero, in_entry;
  assign in_entry = state_q == ENTRY || state_q == PROGRAM;
  lock_cycle_timer u_idle (
    .clk        (clk),
    .rst        (reset),
    .load_i     (in_entry && dig),
    .load_val_i (TIMER_W'(ENTRY_TIMEOUT - 1)),
    .zero_o     (idle_zero)
  );
  assign idle_to = in_entry && cnt_q != '0 && !bus.b0 && !bus.b1 && idle_zero;
`else
  logic unused_timeout;
  assign idle_to        = 1'b0;
  assign unused_timeout = ^ENTRY_TIMEOUT;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ENTRY;
      code_q    <= DEFAULT_CODE;
      entry_q   <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      prog_q    <= 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (abort || idle_to) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end else if (dig && last) begin
            entry_q <= '0;
            cnt_q   <= '0;
            if (match) begin
              state_q  <= OPEN;
              unlock_q <= 1'b1;
              fail_q   <= '0;
            end else if (fail_q == FW'(MAX_FAILS - 1)) begin
              state_q   <= LOCKOUT;
              lockout_q <= 1'b1;
              fail_q    <= FW'(MAX_FAILS);
            end else fail_q <= fail_q + FW'(1);
          end else if (dig) begin
            entry_q <= entry_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        OPEN: begin
          if (bus.prog_req) begin
            state_q  <= PROGRAM;
            unlock_q <= 1'b0;
            prog_q   <= 1'b1;
            entry_q  <= '0;
            cnt_q    <= '0;
          end else if (win_zero) begin
            state_q  <= ENTRY;
            unlock_q <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (win_zero) begin
            state_q   <= ENTRY;
            lockout_q <= 1'b0;
            fail_q    <= '0;
          end
        end
        PROGRAM: begin
          if (abort || idle_to || (dig && last)) begin
            state_q <= ENTRY;
            prog_q  <= 1'b0;
            entry_q <= '0;
            cnt_q   <= '0;
            if (dig) code_q <= entry_d;
          end else if (dig) begin
            entry_q <= entry_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end
  assign bus.unlock    = unlock_q;
  assign bus.lockout   = lockout_q;
  assign bus.prog_mode = prog_q;
  assign bus.fail_cnt  = fail_q;
endmodule

// File: doc/lock_access_controller.md
Name: lock_access_controller

Overview:
- Sequencing controller for the two-button electronic lock.
- Collects serial code digits from buttons b0 (digit 0) and b1 (digit 1) and compares them against a stored code.
- Drives a timed unlock pulse, counts failed attempts and enforces a lockout window.
- Allows the code to be reprogrammed while the lock is open; sits between the button debounce logic and the door actuator.

Parameters:
- CODE_LEN, 5, number of digits per code (1..16).
- DEFAULT_CODE, 5'b01011, code loaded at reset; first digit entered is the MSB.
- UNLOCK_CYCLES, 4, cycles unlock stays high after a correct code (>=1).
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCKOUT_CYCLES, 8, lockout duration in cycles (>=1).
- ENTRY_TIMEOUT, 16, idle cycles allowed between digits; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- b0  in  1  digit-0 button, sampled each posedge, one cycle per press.
- b1  in  1  digit-1 button, sampled each posedge.
- prog_req  in  1  request to reprogram the code; honoured only in OPEN.
- unlock  out  1  door release, registered.
- lockout  out  1  high during lockout, registered.
- prog_mode  out  1  high while a new code is being entered, registered.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures, registered.

Behaviour:
- One clock, clk; reset synchronous active-high. On reset:
  - state=ENTRY, code=DEFAULT_CODE, digit count=0, timer=0.
  - unlock=0, lockout=0, prog_mode=0, fail_cnt=0.
- Digit event: b0^b1 high at a posedge; digit value = b1.
- Abort event: b0&b1 high. It clears the partial entry and the digit count, and does not count as a fail.
- Neither button high: no action.
- States: ENTRY, OPEN, LOCKOUT, PROGRAM.
- ENTRY:
  - Each digit shifts into the entry register, MSB first, and the count increments.
  - At the edge sampling digit CODE_LEN, compare (entry<<1 | digit) with code.
  - Match: go to OPEN, unlock=1 from that edge, fail_cnt=0, timer=UNLOCK_CYCLES-1.
  - Mismatch: fail_cnt+1. If it reaches MAX_FAILS, go to LOCKOUT with lockout=1 and timer=LOCKOUT_CYCLES-1; otherwise stay in ENTRY.
  - The count clears in all cases.
- OPEN:
  - Button events are ignored.
  - Timer decrements each cycle. When timer==0 and prog_req is low: unlock=0, go to ENTRY.
  - prog_req high on any OPEN cycle, including the last: go to PROGRAM, unlock=0, prog_mode=1, count=0.
- PROGRAM:
  - Digits shift into the entry register.
  - At digit CODE_LEN: code <= new value, prog_mode=0, go to ENTRY.
  - Abort: keep the old code, prog_mode=0, go to ENTRY.
- LOCKOUT:
  - All inputs are ignored.
  - Timer decrements. At timer==0: lockout=0, fail_cnt=0, go to ENTRY.
  - The first digit can be accepted on the cycle after lockout falls.
- Latency: unlock and lockout are visible one cycle after the deciding edge; no combinational input-to-output path.
- fail_cnt saturates at MAX_FAILS and is never observed above it.
- Reset mid-operation: immediate return to reset values. A programmed code is lost and the code reverts to DEFAULT_CODE.

Optional Feature:
- Macro LOCK_ENTRY_TIMEOUT_EN.
- Defined: in ENTRY and PROGRAM, an idle counter runs while count>0 and clears on each digit. On reaching ENTRY_TIMEOUT idle cycles, the partial entry is discarded as if aborted (no fail). PROGRAM also returns to ENTRY with prog_mode=0.
- Undefined: no idle counter; a partial entry waits indefinitely.

Decomposition:
- Package lock_ctrl_pkg:
  - state enum lock_state_e {ENTRY, OPEN, LOCKOUT, PROGRAM}.
  - localparams for digit-count and timer widths.
  - default code constant.
- Sub-module lock_cycle_timer: loadable down counter with a load value input, load strobe, and zero flag. It is shared by the OPEN/LOCKOUT windows; the optional idle counter uses a second instance.

Test Plan:
- Reset, then digits 0,1,0,1,1 on consecutive cycles -> unlock high for exactly 4 cycles starting the cycle after the 5th digit; fail_cnt=0.
- Three wrong codes of 11111 -> fail_cnt goes 1,2, then lockout=1 for 8 cycles; digits entered during lockout are ignored; fail_cnt=0 afterwards; correct code then unlocks.
- Enter 01011, assert prog_req in OPEN, enter 10010 -> prog_mode falls and code is updated; 01011 now fails, 10010 unlocks.
- Partial entry 0,1 then b0=b1=1, then 01011 -> unlock with no fail recorded; abort during PROGRAM keeps the old code.
- Reset asserted mid-entry and mid-OPEN -> next cycle unlock=0, count cleared; DEFAULT_CODE active again after a reprogram.
- With LOCK_ENTRY_TIMEOUT_EN: digit 0, then 16 idle cycles, then 01011 -> unlock asserts, fail_cnt=0; without the macro the same stimulus records a fail.
